// File: rtl/neo_frame_sequencer.sv
// NeoPixel frame sequencer: streams G,R,B bytes per pixel, then a send strobe, then an idle gap.
// Optional BRIGHTNESS_SCALE_EN adds a brightness input that scales every presented level.
module neo_frame_sequencer #(
  parameter int NUM_PIXELS = 5,
  parameter int LEVEL_W    = 8,
  parameter int FRAME_GAP  = 16,
  parameter int HUE_STEP   = 8,
  localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [1:0]         mode,
  input  logic [LEVEL_W-1:0] base_level,
`ifdef BRIGHTNESS_SCALE_EN
  input  logic [LEVEL_W-1:0] brightness,
`endif
  input  logic               ready_to_load,
  input  logic               ready_to_send,
  output logic [PIX_W-1:0]   pixel_index,
  output logic [1:0]         color_index,
  output logic [LEVEL_W-1:0] color_level,
  output logic               load_color,
  output logic               send_it,
  output logic               busy,
  output logic               frame_done
);

  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;
  typedef enum logic [1:0] {M_SOLID, M_CHASE, M_RAMP, M_OFF} mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         col_q, col_d;
  logic [LEVEL_W-1:0] phase_q, phase_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;

  logic               pix_last, gap_last;
  logic [LEVEL_W-1:0] phase_next, ramp_r, pattern_level;

  assign pix_last = (pix_q == PIX_W'(NUM_PIXELS - 1));
  assign gap_last = (gap_q == GAP_W'(FRAME_GAP - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_SOLID;
      pix_q   <= '0;
      col_q   <= '0;
      phase_q <= '0;
      gap_q   <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      lvl_q   <= lvl_d;
    end
  end

  // CHASE phase walks the pixel positions; other modes use it as a free-running level offset.
  always_comb begin
    if (mode_q == M_CHASE)
      phase_next = (phase_q == LEVEL_W'(NUM_PIXELS - 1)) ? '0 : phase_q + 1'b1;
    else
      phase_next = phase_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pix_d   = pix_q;
    col_d   = col_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    lvl_d   = lvl_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode_e'(mode);
          lvl_d   = base_level;
          pix_d   = '0;
          col_d   = '0;
          phase_d = '0;
        end
      end
      S_LOAD: begin
        if (ready_to_load) begin
          if (col_q == 2'd2) begin
            col_d = '0;
            if (pix_last) begin
              pix_d   = '0;
              state_d = S_SEND;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_SEND: begin
        if (ready_to_send) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          phase_d = phase_next;
          gap_d   = '0;
          pix_d   = '0;
          col_d   = '0;
          state_d = (continuous && !stop) ? S_LOAD : S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ramp_r = phase_q + LEVEL_W'(32'(pix_q) * HUE_STEP);

  always_comb begin
    pattern_level = '0;
    case (mode_q)
      M_SOLID: pattern_level = lvl_q;
      M_CHASE: pattern_level = (LEVEL_W'(pix_q) == phase_q) ? lvl_q : '0;
      M_RAMP: begin
        if (col_q == 2'd0)      pattern_level = ramp_r;
        else if (col_q == 2'd1) pattern_level = ~ramp_r;
        else                    pattern_level = '0;
      end
      default: pattern_level = '0;
    endcase
  end

  always_comb begin
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    busy        = (state_q != S_IDLE);
    frame_done  = (state_q == S_GAP) && gap_last;
    case (state_q)
      S_LOAD: begin
        pixel_index = pix_q;
        color_index = col_q;
`ifdef BRIGHTNESS_SCALE_EN
        color_level = LEVEL_W'(((2*LEVEL_W)'(pattern_level) * (2*LEVEL_W)'(brightness)) >> LEVEL_W);
`else
        color_level = pattern_level;
`endif
        load_color  = ready_to_load;
      end
      S_SEND:  send_it = ready_to_send;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Scoreboard bench for neo_frame_sequencer: expected bytes are queued per run from a
// pattern model, and a negedge monitor checks every strobe the DUT presents.
module tb_neo_frame_sequencer;
  localparam int NP   = 5;
  localparam int LW   = 8;
  localparam int GAP  = 16;
  localparam int HS   = 8;
  localparam int LMOD = 1 << LW;

  logic          clock = 1'b0;
  logic          reset_n, start, stop, continuous, ready_to_load, ready_to_send;
  logic [1:0]    mode;
  logic [LW-1:0] base_level;
  logic [2:0]    pixel_index;
  logic [1:0]    color_index;
  logic [LW-1:0] color_level;
  logic          load_color, send_it, busy, frame_done;
`ifdef BRIGHTNESS_SCALE_EN
  logic [LW-1:0] brightness;
  int            cur_br = 255;
`endif

  neo_frame_sequencer #(.NUM_PIXELS(NP), .LEVEL_W(LW), .FRAME_GAP(GAP), .HUE_STEP(HS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .continuous(continuous),
    .mode(mode), .base_level(base_level),
`ifdef BRIGHTNESS_SCALE_EN
    .brightness(brightness),
`endif
    .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
    .pixel_index(pixel_index), .color_index(color_index), .color_level(color_level),
    .load_color(load_color), .send_it(send_it), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {int pix; int col; int lvl;} exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0, cyc = 0;
  int sends, dones, frame_loads, total_loads, last_send_cyc, first_load_cyc;
  bit mon_en = 1'b0, nobubble = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pattern rules in plain arithmetic: the byte a given pixel/channel should carry.
  function automatic int model_level(input int m, input int lvl, input int ph, input int pix,
                                     input int col);
    int v, r;
    v = 0;
    case (m)
      0: v = lvl;
      1: v = (pix == ph) ? lvl : 0;
      2: begin
        r = (ph + pix * HS) % LMOD;
        v = (col == 0) ? r : (col == 1) ? (LMOD - 1 - r) : 0;
      end
      default: v = 0;
    endcase
`ifdef BRIGHTNESS_SCALE_EN
    v = (v * cur_br) >> LW;
`endif
    return v;
  endfunction

  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      if (load_color) begin
        exp_t e;
        check("load_gated_by_ready", int'(ready_to_load), 1);
        check("load_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel_index", int'(pixel_index), e.pix);
          check("color_index", int'(color_index), e.col);
          check("color_level", int'(color_level), e.lvl);
        end
        frame_loads++;
        total_loads++;
        if (frame_loads == 1) first_load_cyc = cyc;
        if (nobubble && frame_loads == 3 * NP)
          check("no_bubble_span", cyc - first_load_cyc, 3 * NP - 1);
      end
      if (send_it) begin
        check("loads_per_frame", frame_loads, 3 * NP);
        frame_loads = 0;
        sends++;
        last_send_cyc = cyc;
      end
      if (frame_done) begin
        check("gap_after_send", cyc - last_send_cyc, GAP);
        dones++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_load_color"}, int'(load_color), 0);
    check({tag, "_send_it"}, int'(send_it), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_pixel_index"}, int'(pixel_index), 0);
    check({tag, "_color_index"}, int'(color_index), 0);
    check({tag, "_color_level"}, int'(color_level), 0);
  endtask

  // One run: nf frames from a single start; stop rises during the last frame's load.
  task automatic run(input int m, input int lvl, input int nf, input bit rl_full, input int abort_at);
    int ph;
    bit aborted;
    ph = 0;
    aborted = 1'b0;
    sends = 0; dones = 0; frame_loads = 0; total_loads = 0;
    nobubble = rl_full;
    for (int f = 0; f < nf; f++) begin
      for (int p = 0; p < NP; p++)
        for (int c = 0; c < 3; c++)
          exp_q.push_back('{p, c, model_level(m, lvl, ph, p, c)});
      ph = (m == 1) ? (ph + 1) % NP : (ph + 1) % LMOD;
    end
`ifdef BRIGHTNESS_SCALE_EN
    brightness = LW'(cur_br);
`endif
    mode = 2'(m); base_level = LW'(lvl);
    continuous = (nf > 1); stop = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 5000; k++) begin
      start = 1'b0;
      if (dones >= nf) break;
      if (abort_at > 0 && total_loads >= abort_at) begin
        mon_en = 1'b0;
        reset_n = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        #1;
        check_all_zero("reset_mid_load");
        @(posedge clock); #1;
        check("reset_held_busy", int'(busy), 0);
        reset_n = 1'b1;
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      ready_to_load = rl_full ? 1'b1 : ($urandom_range(0, 3) != 0);
      ready_to_send = ($urandom_range(0, 2) == 0);
      if (nf > 1 && dones >= nf - 1) stop = 1'b1;
      if (busy && $urandom_range(0, 19) == 0) begin
        start = 1'b1;
        mode = 2'($urandom);
        base_level = LW'($urandom);
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    if (!aborted) begin
      check("frames_done", dones, nf);
      repeat (GAP + 4) begin
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        @(posedge clock); #1;
      end
      check("idle_after_run", int'(busy), 0);
      check("sends_per_run", sends, nf);
      check("frame_done_per_run", dones, nf);
      check("scoreboard_drained", exp_q.size(), 0);
    end
    stop = 1'b0;
    continuous = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    mode = '0; base_level = '0; ready_to_load = 1'b1; ready_to_send = 1'b1;
`ifdef BRIGHTNESS_SCALE_EN
    brightness = '1;
`endif
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("in_reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all_zero("after_reset");
    mon_en = 1'b1;

    run(0, 'h33, 1, 1'b0, 4);
    run(0, 'h40, 1, 1'b1, 0);
    run(1, 'hA5, 6, 1'b0, 0);
    run(2, 'h00, 1, 1'b0, 0);
    run(2, 'h11, 3, 1'b1, 0);
    run(0, 'h5A, 2, 1'b0, 0);
    run(3, 'hFF, 2, 1'b0, 0);
`ifdef BRIGHTNESS_SCALE_EN
    cur_br = 'h80;
`endif
    run(0, 'hFF, 1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
`ifdef BRIGHTNESS_SCALE_EN
      cur_br = $urandom_range(0, LMOD - 1);
`endif
      run($urandom_range(0, 3), $urandom_range(0, LMOD - 1), $urandom_range(1, 4),
          1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
